// File: rtl/msb_pkg.sv
// msb_pkg: shared types and constants for the msb read-request generator.
// Defines the burst FSM state, the number of 64-bit elements covered by one
// read request, and the request-address width derived from the BRAM geometry.
package msb_pkg;

    // Burst sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One request covers one 128-bit output beat, i.e. two 64-bit elements
    localparam int unsigned ELEM_PER_REQ = 2;

    // Request address width: element offset within line plus line index,
    // minus one bit because requests are issued at two-element granularity
    // on the bram_top read port.
    function automatic int unsigned req_addr_width(input int unsigned ways,
                                                   input int unsigned ram_depth);
        return $clog2(ways) + $clog2(ram_depth) - 1;
    endfunction

endpackage

// File: rtl/msb_credit_cnt.sv
// msb_credit_cnt: up/down counter of read requests in flight.
// Increments on an accepted request, decrements on a consumed response, and
// holds when both happen in the same cycle. Reports whether another request
// may be issued next cycle and flags a response arriving with nothing
// outstanding (the count is left at zero in that case).
module msb_credit_cnt
    import msb_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             clk1x,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt_next,
    output logic             has_credit,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt;

    // Next count, credit availability and underflow detection
    always_comb begin
        cnt_next  = cnt;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (cnt != '1) begin
                cnt_next = cnt + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_next = cnt - CNT_W'(1);
            end
        end
        has_credit = (cnt_next < CNT_W'(MAX_OUT));
    end

    // Outstanding count register
    always_ff @(posedge clk1x) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/msb_rd_req_gen.sv
// msb_rd_req_gen: read-request generator feeding bram_top's read interface.
// Accepts a burst command (start element address, request count), issues one
// two-element read request per cycle on req_v/req_r while fewer than MAX_OUT
// are in flight, walks the address with wrap-around, and pulses done once
// every response of the burst has been consumed (rsp_ack).
// Optional build macro MSB_RDGEN_STATS_EN adds the saturating stat_req and
// stat_stall counters; without it those ports do not exist.
module msb_rd_req_gen
    import msb_pkg::*;
#(
    parameter  int unsigned WAYS      = 8,
    parameter  int unsigned RAM_DEPTH = 512,
    parameter  int unsigned LEN_W     = 12,
    parameter  int unsigned MAX_OUT   = 4,
    localparam int unsigned AW        = req_addr_width(WAYS, RAM_DEPTH)
) (
    input  logic             clk1x,
    input  logic             reset,
    input  logic             cmd_v,
    output logic             cmd_r,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             req_v,
    input  logic             req_r,
    output logic [AW-1:0]    req_d,
    input  logic             rsp_ack,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef MSB_RDGEN_STATS_EN
    ,
    output logic [31:0]      stat_req,
    output logic [31:0]      stat_stall
`endif
);

    localparam int unsigned CNT_W     = $clog2(MAX_OUT + 1);
    localparam logic [AW-1:0] EVEN_MASK = ~AW'(1);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] rem_next;
    logic [CNT_W-1:0] out_next;
    logic             has_credit;
    logic             underflow;
    logic             hs;

    assign hs       = req_v && req_r;
    assign rem_next = hs ? (remaining - LEN_W'(1)) : remaining;
    assign cmd_r    = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);

    msb_credit_cnt #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_credit (
        .clk1x      (clk1x),
        .reset      (reset),
        .inc        (hs),
        .dec        (rsp_ack),
        .cnt_next   (out_next),
        .has_credit (has_credit),
        .underflow  (underflow)
    );

    // Burst FSM with registered request valid/address, done pulse and sticky error.
    // req_v is computed from the post-update credit and remaining counts so it
    // stays registered yet reacts to a response in the same cycle it arrives.
    always_ff @(posedge clk1x) begin
        if (reset) begin
            state     <= IDLE;
            req_v     <= 1'b0;
            req_d     <= '0;
            remaining <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (underflow) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cmd_v && cmd_r) begin
                        req_d     <= cmd_addr & EVEN_MASK;
                        remaining <= cmd_len;
                        if (cmd_len != '0) begin
                            state <= RUN;
                            req_v <= has_credit;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        req_d <= req_d + AW'(ELEM_PER_REQ);
                    end
                    remaining <= rem_next;
                    req_v     <= (req_v && !req_r) || (has_credit && (rem_next != '0));
                    if (rem_next == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_next == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_v <= 1'b0;
                end
            endcase
        end
    end

`ifdef MSB_RDGEN_STATS_EN
    // Saturating counters of accepted requests and back-pressured request cycles
    always_ff @(posedge clk1x) begin
        if (reset) begin
            stat_req   <= '0;
            stat_stall <= '0;
        end else begin
            if (hs && (stat_req != '1)) begin
                stat_req <= stat_req + 32'd1;
            end
            if (req_v && !req_r && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_msb_rd_req_gen.sv
// tb_msb_rd_req_gen: scoreboard bench for msb_rd_req_gen.
// The driver issues bursts and models the downstream responder; each issued
// command is queued, and an independent monitor derives the expected request
// addresses, valid/ready behaviour, done timing and error flag from the
// burst rules and compares on every falling edge.
module tb_msb_rd_req_gen;

    localparam int unsigned WAYS      = 8;
    localparam int unsigned RAM_DEPTH = 512;
    localparam int unsigned LEN_W     = 12;
    localparam int unsigned MAX_OUT   = 4;
    localparam int unsigned AW        = 11;
    localparam int unsigned ASPACE    = 1 << AW;

    logic             clk1x = 1'b0;
    logic             reset;
    logic             cmd_v;
    logic             cmd_r;
    logic [AW-1:0]    cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             req_v;
    logic             req_r;
    logic [AW-1:0]    req_d;
    logic             rsp_ack;
    logic             busy;
    logic             done;
    logic             err;
`ifdef MSB_RDGEN_STATS_EN
    logic [31:0]      stat_req;
    logic [31:0]      stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned addr;
        int unsigned len;
    } burst_t;

    burst_t      burst_q[$];
    int unsigned addr_q[$];

    // driver state
    int ack_mode  = 1;   // 0 never, 1 always when pending, 2 random
    int rr_mode   = 1;   // 0 never ready, 1 always ready, 2 random
    bit force_ack = 1'b0;
    int pend      = 0;
    bit acc       = 1'b0;
    bit saw_done  = 1'b0;

    // monitor-side event counts for the statistics build
    int m_hs    = 0;
    int m_stall = 0;

    msb_rd_req_gen #(
        .WAYS      (WAYS),
        .RAM_DEPTH (RAM_DEPTH),
        .LEN_W     (LEN_W),
        .MAX_OUT   (MAX_OUT)
    ) dut (
        .clk1x    (clk1x),
        .reset    (reset),
        .cmd_v    (cmd_v),
        .cmd_r    (cmd_r),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .req_v    (req_v),
        .req_r    (req_r),
        .req_d    (req_d),
        .rsp_ack  (rsp_ack),
        .busy     (busy),
        .done     (done),
        .err      (err)
`ifdef MSB_RDGEN_STATS_EN
        ,
        .stat_req   (stat_req),
        .stat_stall (stat_stall)
`endif
    );

    always #5 clk1x = ~clk1x;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: observe what the coming edge will do, then drive the next cycle.
    task automatic tick();
        @(negedge clk1x);
        acc      = cmd_v && cmd_r;
        saw_done = saw_done || done;
        if (reset) begin
            pend = 0;
        end else begin
            if (req_v && req_r) pend++;
            if (rsp_ack) pend--;
        end
        @(posedge clk1x);
        #1;
        if (acc) cmd_v = 1'b0;
        rsp_ack = force_ack ||
                  ((pend > 0) && ((ack_mode == 1) ||
                                  ((ack_mode == 2) && ($urandom_range(0, 1) == 1))));
        case (rr_mode)
            0:       req_r = 1'b0;
            1:       req_r = 1'b1;
            default: req_r = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic issue(input int unsigned a, input int unsigned l);
        int n;
        burst_q.push_back('{a, l});
        cmd_addr = AW'(a);
        cmd_len  = LEN_W'(l);
        cmd_v    = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc && n < 3000);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of addr %0d len %0d", a, l);
            cmd_v = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        saw_done = 1'b0;
        n = 0;
        while (!saw_done && n < 3000) begin
            tick();
            n++;
        end
        if (!saw_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
        end
    endtask

    // Monitor / reference model, sampled on the falling edge
    initial begin : monitor
        int          m_out;
        int          m_rem;
        int          done_due;
        bit          active;
        bit          m_err;
        bit          prev_stall;
        bit          exp_idle;
        logic [AW-1:0] prev_d;
        burst_t      b;
        m_out = 0; m_rem = 0; done_due = 0;
        active = 1'b0; m_err = 1'b0; prev_stall = 1'b0; prev_d = '0;
        forever begin
            @(negedge clk1x);
            if (reset) begin
                m_out = 0; m_rem = 0; done_due = 0;
                active = 1'b0; m_err = 1'b0; prev_stall = 1'b0;
                m_hs = 0; m_stall = 0;
                addr_q.delete();
                continue;
            end
            exp_idle = !active && (done_due <= 1);
            check("done", done, (done_due == 1));
            check("cmd_r", cmd_r, exp_idle);
            check("busy", busy, !exp_idle);
            check("req_v", req_v, active && (m_rem > 0) && (m_out < MAX_OUT));
            check("err", err, m_err);
            if (prev_stall) begin
                check("stall_hold_v", req_v, 1);
                check("stall_hold_d", req_d, prev_d);
            end
            if (done_due > 0) done_due--;

            if (cmd_v && cmd_r) begin
                if (burst_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_accept: got accept expected no pending command");
                end else begin
                    b = burst_q.pop_front();
                    for (int unsigned i = 0; i < b.len; i++) begin
                        addr_q.push_back(((b.addr & ~32'd1) + 2 * i) % ASPACE);
                    end
                    if (b.len == 0) begin
                        done_due = 2;
                    end else begin
                        active = 1'b1;
                        m_rem  = b.len;
                    end
                end
            end

            if (req_v && req_r) begin
                m_hs++;
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_extra: got request addr %0d expected none", req_d);
                end else begin
                    check("req_d", req_d, addr_q.pop_front());
                end
                if (m_rem > 0) m_rem--;
                m_out++;
            end
            if (req_v && !req_r) m_stall++;
            if (rsp_ack) begin
                if (m_out == 0) m_err = 1'b1;
                else m_out--;
            end
            if (active && (m_rem == 0) && (m_out == 0)) begin
                active   = 1'b0;
                done_due = 1;
            end
            prev_stall = req_v && !req_r;
            prev_d     = req_d;
        end
    end

    // Stimulus
    initial begin
        reset = 1'b1; cmd_v = 1'b0; cmd_addr = '0; cmd_len = '0;
        req_r = 1'b0; rsp_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // plain burst, immediate acceptance and responses
        ack_mode = 1; rr_mode = 1;
        issue(160, 3);
        wait_done();

        // address wrap at the top of the request space
        issue(2044, 4);
        wait_done();

        // credit limit: no responses, then a single response
        ack_mode = 0;
        issue(40, 8);
        repeat (8) tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        repeat (4) tick();
        ack_mode = 1;
        wait_done();

        // back-pressure mid-burst
        issue(500, 6);
        tick();
        rr_mode = 0;
        repeat (5) tick();
        rr_mode = 1;
        wait_done();

        // zero-length burst with odd address
        issue(161, 0);
        wait_done();

        // reset mid-burst, then a stray response
        ack_mode = 0;
        issue(0, 10);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // randomized back-to-back bursts
        ack_mode = 2; rr_mode = 2;
        for (int k = 0; k < 40; k++) begin
            issue($urandom_range(0, ASPACE - 1), $urandom_range(0, 12));
        end
        wait_done();
        ack_mode = 1; rr_mode = 1;
        repeat (5) tick();

`ifdef MSB_RDGEN_STATS_EN
        check("stat_req", stat_req, m_hs);
        check("stat_stall", stat_stall, m_stall);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on run time
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
